fifo_level: RTL and testbench

// - Parametrised first-word-fall-through (FWFT) sample FIFO for the audio DSP path.
// - Adds to the basic FIFO: occupancy count, programmable almost-full/almost-empty flags, synchronous flush.
// - Sits between the audio codec sample interface and the filter datapath; flags drive producer/consumer throttling.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_level_if.sv | 44 ++++
 rtl/fifo_mem.sv | 39 +++
 rtl/fifo_level.sv | 136 +++++++++++++
 tb/tb_fifo_level.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the fifo_level sample FIFO.
//   - Default width parameters for the audio sample path.
//   - fifo_depth / fifo_cnt_w: derive the entry count and occupancy counter width
//     from the address width.
//   - fifo_status_t: the decoded occupancy flags.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DEF_DATA_WIDTH = 24;
  localparam int FIFO_DEF_ADDR_WIDTH = 3;

  // Number of entries for a given address width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // The counter must hold 0..DEPTH inclusive, so it needs one extra bit.
  function automatic int fifo_cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

endpackage

// File: rtl/fifo_level_if.sv
// -----------------------------------------------------------------------------
// fifo_level_if
// Groups the sample FIFO's request, data and status signals.
//   master : drives flush, wr, w_data, rd; receives r_data, status, count, errors
//   slave  : the FIFO side (mirror of master)
//
// Handshake: a write is taken on a rising clock edge when wr=1 and
// (full=0 or rd=1), and flush=0. A read pops the head on a rising clock edge
// when rd=1, empty=0 and flush=0. r_data always shows the head word and is
// meaningful only while empty=0. There is no back-pressure beyond full/empty.
// The producer must watch full (or almost_full), and the consumer must watch
// empty (or almost_empty).
// -----------------------------------------------------------------------------
interface fifo_level_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 3
);

  logic                  flush;
  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr, w_data, rd,
    input  r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  flush, wr, w_data, rd,
    output r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_WIDTH register array. The write is synchronous and the read is
// asynchronous. The array has no reset, because its contents are only
// meaningful behind the FIFO pointers.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  mem[raddr_i], combinational
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_level.sv
// -----------------------------------------------------------------------------
// fifo_level
// First-word-fall-through sample FIFO with an occupancy count, programmable
// almost-full and almost-empty flags, and a synchronous flush.
//   clk    in     single clock, all state on posedge
//   reset  in     asynchronous, active-high
//   bus    slave  flush/wr/w_data/rd in; r_data, empty, full, almost_empty,
//                 almost_full, count, overflow, underflow out
// Optional macro FIFO_ERR_FLAGS_EN: builds sticky overflow/underflow registers.
// Without it, both ports are tied low.
// -----------------------------------------------------------------------------
module fifo_level
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = fifo_depth(FIFO_DEF_ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1
) (
  input logic        clk,
  input logic        reset,
  fifo_level_if.slave bus
);

  localparam int CW = fifo_cnt_w(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  fifo_status_t          status;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flags come only from the registered count, so they change once per edge.
  always_comb begin
    status.empty        = (count_q == '0);
    status.full         = (count_q == DEPTH_C);
    status.almost_empty = (count_q <= AE_C);
    status.almost_full  = (count_q >= AF_C);
  end

  // A write while full is still taken when a read frees a slot in the same
  // cycle. A read while empty is simply dropped. Flush overrides both.
  assign wr_ok = bus.wr & (~status.full | bus.rd) & ~bus.flush;
  assign rd_ok = bus.rd & ~status.empty & ~bus.flush;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    if (bus.flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (wr_ok) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
      if (rd_ok) r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
      if (wr_ok && !rd_ok) begin
        count_d = count_q + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (w_ptr_q),
    .wdata_i (bus.w_data),
    .raddr_i (r_ptr_q),
    .rdata_o (bus.r_data)
  );

  assign bus.empty        = status.empty;
  assign bus.full         = status.full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Only pure misuse is flagged. A write while full that is paired with a read,
  // or a read while empty that is paired with a write, is legal traffic.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.flush) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (bus.wr && status.full && !bus.rd)  ovf_d = 1'b1;
      if (bus.rd && status.empty && !bus.wr) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// -----------------------------------------------------------------------------
// tb_fifo_level
// Directed bench for fifo_level (24-bit data, 8 entries, AF=6, AE=1).
// A table of {inputs, expected outputs} covers fill, overflow and drain.
// Hand-written sequences cover the multi-cycle corners: empty rd+wr, underflow,
// full rd+wr with pointer wrap, flush, and asynchronous reset between clock edges.
// -----------------------------------------------------------------------------
module tb_fifo_level;
  import fifo_pkg::*;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [23:0] exp_q[$];

  fifo_level_if #(.DATA_WIDTH(24), .ADDR_WIDTH(3)) bus ();

  fifo_level #(
    .DATA_WIDTH (24),
    .ADDR_WIDTH (3),
    .AF_THRESH  (6),
    .AE_THRESH  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        fl;
    logic        wr;
    logic        rd;
    logic [23:0] wd;
    logic [3:0]  cnt;
    logic        emp;
    logic        ful;
    logic        ae;
    logic        af;
    logic        dchk;
    logic [23:0] rdat;
    logic        ovf;
    logic        unf;
    string       tag;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic fl, input logic wr, input logic rd,
                              input logic [23:0] wd, input logic [3:0] cnt,
                              input logic emp, input logic ful, input logic ae,
                              input logic af, input logic dchk,
                              input logic [23:0] rdat, input logic ovf,
                              input logic unf, input string tag);
    vec_t v;
    v.fl = fl; v.wr = wr; v.rd = rd; v.wd = wd; v.cnt = cnt;
    v.emp = emp; v.ful = ful; v.ae = ae; v.af = af; v.dchk = dchk;
    v.rdat = rdat; v.ovf = ovf; v.unf = unf; v.tag = tag;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic f, input logic w, input logic r,
                       input logic [23:0] d);
    bus.flush  = f;
    bus.wr     = w;
    bus.rd     = r;
    bus.w_data = d;
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // The flags are derived here from the expected count and the thresholds
  // (DEPTH=8, AF=6, AE=1).
  task automatic check_flags(input string tag, input int cnt,
                             input logic ovf, input logic unf);
    check({tag, ".count"},        32'(bus.count),        32'(cnt));
    check({tag, ".empty"},        32'(bus.empty),        32'(cnt == 0));
    check({tag, ".full"},         32'(bus.full),         32'(cnt == 8));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= 1));
    check({tag, ".almost_full"},  32'(bus.almost_full),  32'(cnt >= 6));
    check({tag, ".overflow"},     32'(bus.overflow),     32'(ovf));
    check({tag, ".underflow"},    32'(bus.underflow),    32'(unf));
  endtask

  initial begin
    // ---- table: fill 8, overflow attempt, drain 8 ----
    for (int i = 1; i <= 8; i++) begin
      tbl.push_back(mk(0, 1, 0, 24'(i), 4'(i), 0, i == 8, i <= 1, i >= 6,
                       1, 24'h000001, 0, 0, "fill"));
    end
    tbl.push_back(mk(0, 1, 0, 24'hBADBAD, 4'd8, 0, 1, 0, 1, 1, 24'h000001,
                     ERR_EN, 0, "ovf"));
    for (int k = 1; k <= 8; k++) begin
      tbl.push_back(mk(0, 0, 1, 24'h0, 4'(8 - k), (8 - k) == 0, 0,
                       (8 - k) <= 1, (8 - k) >= 6, k < 8, 24'(k + 1),
                       ERR_EN, 0, "drain"));
    end

    // ---- reset ----
    reset = 1'b1;
    drive(0, 0, 0, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset", 0, 0, 0);
    reset = 1'b0;

    // ---- table-driven vectors ----
    foreach (tbl[n]) begin
      drive(tbl[n].fl, tbl[n].wr, tbl[n].rd, tbl[n].wd);
      step();
      check({tbl[n].tag, ".count"},  32'(bus.count),        32'(tbl[n].cnt));
      check({tbl[n].tag, ".empty"},  32'(bus.empty),        32'(tbl[n].emp));
      check({tbl[n].tag, ".full"},   32'(bus.full),         32'(tbl[n].ful));
      check({tbl[n].tag, ".ae"},     32'(bus.almost_empty), 32'(tbl[n].ae));
      check({tbl[n].tag, ".af"},     32'(bus.almost_full),  32'(tbl[n].af));
      check({tbl[n].tag, ".ovf"},    32'(bus.overflow),     32'(tbl[n].ovf));
      check({tbl[n].tag, ".unf"},    32'(bus.underflow),    32'(tbl[n].unf));
      if (tbl[n].dchk) begin
        check({tbl[n].tag, ".r_data"}, 32'(bus.r_data), 32'(tbl[n].rdat));
      end
    end

    // ---- empty: rd+wr together -> write only, no underflow ----
    drive(0, 1, 1, 24'h9078DB);
    step();
    check_flags("empty_rdwr", 1, ERR_EN, 0);
    check("empty_rdwr.r_data", 32'(bus.r_data), 32'h9078DB);
    drive(0, 0, 1, 24'h0);
    step();
    check_flags("pop_one", 0, ERR_EN, 0);
    // read while empty -> underflow
    drive(0, 0, 1, 24'h0);
    step();
    check_flags("underflow", 0, ERR_EN, ERR_EN);

    // ---- flush clears the error flags ----
    drive(1, 0, 0, 24'h0);
    step();
    check_flags("flush_clr", 0, 0, 0);

    // ---- full with rd+wr for 12 cycles: pointer wrap, order kept ----
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 24'h200 + 24'(i));
      exp_q.push_back(24'h200 + 24'(i));
      step();
    end
    check_flags("refill", 8, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 1, 24'h100 + 24'(i));
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(24'h100 + 24'(i));
      check("wrap.count", 32'(bus.count), 32'd8);
      check("wrap.r_data", 32'(bus.r_data), 32'(exp_q[0]));
    end
    check_flags("wrap_end", 8, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check("wrap_drain.r_data", 32'(bus.r_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      drive(0, 0, 1, 24'h0);
      step();
    end
    check_flags("wrap_drained", 0, 0, 0);

    // ---- flush with a write pending ----
    drive(0, 0, 1, 24'h0);
    step();
    check_flags("pre_flush_unf", 0, 0, ERR_EN);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 24'h300 + 24'(i));
      step();
    end
    drive(0, 0, 0, 24'h0);
    check_flags("load5", 5, 0, ERR_EN);
    drive(1, 1, 0, 24'hDEAD00);
    step();
    check_flags("flush", 0, 0, 0);
    drive(0, 1, 0, 24'h000ABC);
    step();
    check_flags("post_flush_wr", 1, 0, 0);
    check("post_flush.r_data", 32'(bus.r_data), 32'h000ABC);

    // ---- asynchronous reset between clock edges ----
    drive(0, 1, 0, 24'h000401);
    step();
    drive(0, 1, 0, 24'h000402);
    step();
    drive(0, 0, 0, 24'h0);
    check_flags("load3", 3, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    // Sampled at posedge+4, before any further clock edge.
    check_flags("async_rst", 0, 0, 0);
    #2;
    reset = 1'b0;
    drive(0, 1, 0, 24'h000055);
    step();
    drive(0, 0, 0, 24'h0);
    check_flags("after_rst", 1, 0, 0);
    check("after_rst.r_data", 32'(bus.r_data), 32'h000055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
